// File: rtl/req_master_pkg.sv
// Shared types and constants for the Q/P request initiator.
// The response holding register keeps RSP_DW data bits; the top's DW must not exceed it.
package req_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int LAT_W = 16;
  localparam logic [LAT_W-1:0] LAT_SAT = 16'hFFFF;
  localparam int RSP_DW = 32;

  typedef struct packed {
    logic [RSP_DW-1:0] data;
    logic              err;
    logic [LAT_W-1:0]  lat;
  } rsp_t;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    logic [LAT_W-1:0] r;
    if (v == LAT_SAT) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/req_master_lat_cnt.sv
// Saturating latency counter with clear/enable; tc flags that the next count hits TC_VALUE.
module req_master_lat_cnt
  import req_master_pkg::*;
#(
  parameter int TC_VALUE = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [LAT_W-1:0] cnt_inc,
  output logic             tc
);

  localparam logic [LAT_W-1:0] TC_C = LAT_W'(TC_VALUE);

  logic [LAT_W-1:0] cnt_r;

  // incremented value and terminal-count decode
  always_comb begin
    cnt_inc = sat_inc(cnt_r);
    tc      = (cnt_inc == TC_C);
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_inc;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/req_master.sv
// Q/P handshake initiator: one outstanding command, response held until the user accepts it.
// Optional abort on response timeout is enabled by defining REQ_MASTER_TIMEOUT_EN.
module req_master
  import req_master_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [AW-1:0]    CMD_ADDR,
  input  logic [DW-1:0]    CMD_WDATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [DW-1:0]    RSP_DATA,
  output logic             RSP_ERR,
  output logic [LAT_W-1:0] RSP_LAT,
  output logic             QVALID,
  output logic [AW-1:0]    QADDR,
  output logic [DW-1:0]    QWDATA,
  input  logic             QREADY,
  input  logic             PVALID,
  input  logic [DW-1:0]    PDATA,
  output logic             SPURIOUS
);

`ifdef REQ_MASTER_TIMEOUT_EN
  localparam logic TIMEOUT_EN_C = 1'b1;
`else
  localparam logic TIMEOUT_EN_C = 1'b0;
`endif

  state_e           state_r, state_nx_s;
  rsp_t             rsp_r, rsp_nx_s;
  logic [AW-1:0]    qaddr_r;
  logic [DW-1:0]    qwdata_r;
  logic             spurious_r;
  logic             accept_s, cnt_clr_s, cnt_en_s, spur_set_s;
  logic             tc_s, timeout_s;
  logic [LAT_W-1:0] cnt_inc_s;

  req_master_lat_cnt #(.TC_VALUE(TIMEOUT_CYCLES)) u_lat_cnt (
    .clk     (CLK),
    .rst     (RST),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .cnt_inc (cnt_inc_s),
    .tc      (tc_s)
  );

  assign timeout_s = TIMEOUT_EN_C & tc_s;

  // next-state, counter control and response capture
  always_comb begin
    state_nx_s = state_r;
    rsp_nx_s   = rsp_r;
    accept_s   = 1'b0;
    cnt_clr_s  = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (CMD_VALID) begin
          accept_s     = 1'b1;
          cnt_clr_s    = 1'b1;
          rsp_nx_s.lat = '0;
          state_nx_s   = ST_REQ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_en_s = 1'b1;
        if (QREADY && PVALID) begin
          rsp_nx_s   = '{data: RSP_DW'(PDATA), err: 1'b0, lat: cnt_inc_s};
          state_nx_s = ST_DONE;
        end else if (QREADY) begin
          state_nx_s = ST_RSP;
        end else if (timeout_s) begin
          rsp_nx_s   = '{data: '0, err: 1'b1, lat: cnt_inc_s};
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_RSP: begin
        cnt_en_s = 1'b1;
        // a response on the timeout edge still counts as a normal completion
        if (PVALID) begin
          rsp_nx_s   = '{data: RSP_DW'(PDATA), err: 1'b0, lat: cnt_inc_s};
          state_nx_s = ST_DONE;
        end else if (timeout_s) begin
          rsp_nx_s   = '{data: '0, err: 1'b1, lat: cnt_inc_s};
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RSP;
        end
      end
      ST_DONE: begin
        if (RSP_READY) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // unexpected response strobe detection
  always_comb begin
    spur_set_s = 1'b0;
    if (PVALID) begin
      spur_set_s = (state_r == ST_IDLE) || (state_r == ST_DONE) ||
                   ((state_r == ST_REQ) && !QREADY);
    end else begin
      spur_set_s = 1'b0;
    end
  end

  // state, request and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      rsp_r      <= '0;
      qaddr_r    <= '0;
      qwdata_r   <= '0;
      spurious_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      rsp_r   <= rsp_nx_s;
      if (accept_s) begin
        qaddr_r  <= CMD_ADDR;
        qwdata_r <= CMD_WDATA;
      end
      if (spur_set_s) begin
        spurious_r <= 1'b1;
      end
    end
  end

  assign CMD_READY = (state_r == ST_IDLE);
  assign QVALID    = (state_r == ST_REQ);
  assign RSP_VALID = (state_r == ST_DONE);
  assign QADDR     = qaddr_r;
  assign QWDATA    = qwdata_r;
  assign RSP_DATA  = DW'(rsp_r.data);
  assign RSP_ERR   = rsp_r.err;
  assign RSP_LAT   = rsp_r.lat;
  assign SPURIOUS  = spurious_r;

endmodule

// File: tb/tb_req_master.sv
// Directed scoreboard bench for req_master; the timeout scenario runs when REQ_MASTER_TIMEOUT_EN is defined.
module tb_req_master;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef REQ_MASTER_TIMEOUT_EN
  localparam int Q_WAIT = 2;
  localparam int P_GAP  = 2;
`else
  localparam int Q_WAIT = 5;
  localparam int P_GAP  = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [AW-1:0] cmd_addr, qaddr;
  logic [DW-1:0] cmd_wdata, rsp_data, qwdata, pdata;
  logic [15:0]   rsp_lat;
  logic          qvalid, qready, pvalid, spurious;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic [15:0]   lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  req_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .RSP_LAT(rsp_lat), .QVALID(qvalid), .QADDR(qaddr), .QWDATA(qwdata), .QREADY(qready),
    .PVALID(pvalid), .PDATA(pdata), .SPURIOUS(spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_cmd(input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
    check("qvalid_rise", qvalid, 1'b1);
    check("qaddr_load", qaddr, addr);
    check("qwdata_load", qwdata, wdata);
  endtask

  // drives the responder side: QREADY after qw waiting cycles, PVALID pg edges later (0 = same edge)
  task automatic do_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int qw, input int pg, input logic [DW-1:0] pd);
    exp_t e;
    e.data = pd;
    e.err  = 1'b0;
    e.lat  = 16'(qw + 1 + pg);
    sb.push_back(e);
    send_cmd(addr, wdata);
    for (int i = 0; i < qw; i++) begin
      tick();
      check("qaddr_stable", qaddr, addr);
      check("qvalid_held", qvalid, 1'b1);
    end
    qready = 1'b1;
    if (pg == 0) begin
      pvalid = 1'b1;
      pdata  = pd;
    end
    tick();
    qready = 1'b0;
    pvalid = 1'b0;
    pdata  = '0;
    check("qvalid_drop", qvalid, 1'b0);
    if (pg > 0) begin
      for (int i = 0; i < pg - 1; i++) tick();
      pvalid = 1'b1;
      pdata  = pd;
      tick();
      pvalid = 1'b0;
      pdata  = '0;
    end
  endtask

  task automatic wait_rsp();
    int   n = 0;
    exp_t e;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check("rsp_valid_wait", rsp_valid, 1'b1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check("rsp_data", rsp_data, e.data);
      check("rsp_err", rsp_err, e.err);
      check("rsp_lat", rsp_lat, e.lat);
      check("qvalid_in_done", qvalid, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_clear", rsp_valid, 1'b0);
    check("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; qready = 1'b0; pvalid = 1'b0; pdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_qvalid", qvalid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_spurious", spurious, 1'b0);
    check("rst_qaddr", qaddr, '0);
    check("rst_qwdata", qwdata, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_lat", rsp_lat, '0);

    // long transaction with delayed handshake and response
    do_txn(32'h10, 32'hA5, Q_WAIT, P_GAP, 32'hDEADBEEF);
    wait_rsp();

    // minimum latency: QREADY and PVALID together on the first REQ edge
    do_txn(32'h14, 32'h5A, 0, 0, 32'h12345678);
    check("min_rsp_valid", rsp_valid, 1'b1);
    wait_rsp();

    // held response blocks a new command; no same-edge bypass
    do_txn(32'h20, 32'h1, 1, 1, 32'hCAFEF00D);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h30;
    cmd_wdata = 32'h77;
    for (int i = 0; i < 10; i++) begin
      check("blocked_cmd_ready", cmd_ready, 1'b0);
      check("held_rsp_data", rsp_data, 32'hCAFEF00D);
      tick();
    end
    wait_rsp();
    check("no_bypass_qvalid", qvalid, 1'b0);
    sb.push_back('{data: 32'h0BADCAFE, err: 1'b0, lat: 16'd1});
    tick();
    cmd_valid = 1'b0;
    check("second_qvalid", qvalid, 1'b1);
    check("second_qaddr", qaddr, 32'h30);
    qready = 1'b1; pvalid = 1'b1; pdata = 32'h0BADCAFE;
    tick();
    qready = 1'b0; pvalid = 1'b0; pdata = '0;
    wait_rsp();

    // spurious response in IDLE is sticky until reset
    pvalid = 1'b1;
    tick();
    pvalid = 1'b0;
    check("spurious_set", spurious, 1'b1);
    do_txn(32'h40, 32'h2, 1, 0, 32'h11112222);
    wait_rsp();
    check("spurious_sticky1", spurious, 1'b1);
    do_txn(32'h44, 32'h3, 0, 2, 32'h33334444);
    wait_rsp();
    check("spurious_sticky2", spurious, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("spurious_rst_clear", spurious, 1'b0);

    // reset while waiting in RSP aborts the command
    send_cmd(32'h50, 32'h4);
    qready = 1'b1;
    tick();
    qready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_qvalid", qvalid, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    check("abort_spurious", spurious, 1'b0);
    tick(); tick();
    check("abort_no_rsp", rsp_valid, 1'b0);
    pvalid = 1'b1; pdata = 32'h99;
    tick();
    pvalid = 1'b0; pdata = '0;
    check("late_pvalid_spurious", spurious, 1'b1);
    check("late_pvalid_no_rsp", rsp_valid, 1'b0);

`ifdef REQ_MASTER_TIMEOUT_EN
    // responder never accepts: abort after 8 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.push_back('{data: '0, err: 1'b1, lat: 16'd8});
    send_cmd(32'h60, 32'h5);
    wait_rsp();
    pvalid = 1'b1;
    tick();
    pvalid = 1'b0;
    check("timeout_late_spurious", spurious, 1'b1);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
